mem_port_arbiter: RTL and testbench

Shares one external memory request/response port between the instruction-fetch requester and the data-memory requester of the RV32 microcoded core. Data requests have fixed priority over fetch, with an anti-starvation counter that forces a fetch grant after a bounded wait. In-order responses are steered back to the issuing requester through a small outstanding-request FIFO. Fetch responses in flight at a redirect can be discarded with `if_kill`.

---
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data requesters
module mem_port_arbiter #(
    parameter int OUTSTANDING  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_data,
    input  logic        if_kill,

    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_req_we,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_data,
    input  logic [1:0]  d_req_size,
    output logic        d_resp_valid,
    output logic [31:0] d_resp_data,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    output logic [1:0]  mem_req_size,
    output logic        mem_req_src,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,

    output logic        err_unexpected_resp
);

    localparam int PW = $clog2(OUTSTANDING);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic [OUTSTANDING-1:0] src_q;
    logic [OUTSTANDING-1:0] killed_q;
    logic [SW-1:0]          starve_cnt;
    logic                   err_q;

    logic can_issue;
    logic fetch_prio;
    logic d_sel;
    logic f_sel;
    logic push;
    logic pop;
    logic head_src;
    logic head_killed;

    // Grants are qualified by reset so every valid/ready is low while reset is held.
    assign can_issue  = (count != CW'(OUTSTANDING));
    assign fetch_prio = (starve_cnt == SW'(STARVE_LIMIT));
    assign d_sel      = reset & d_req_valid & can_issue & ~(fetch_prio & if_req_valid & ~if_kill);
    assign f_sel      = reset & if_req_valid & ~if_kill & can_issue & ~d_sel;

    assign mem_req_valid = d_sel | f_sel;
    assign mem_req_src   = f_sel;
    assign mem_req_we    = d_sel & d_req_we;
    assign mem_req_addr  = d_sel ? d_req_addr : (f_sel ? if_req_addr : 32'd0);
    assign mem_req_data  = d_sel ? d_req_data : 32'd0;
    assign mem_req_size  = d_sel ? d_req_size : (f_sel ? 2'd2 : 2'd0);

    assign d_req_ready  = d_sel & mem_req_ready;
    assign if_req_ready = f_sel & mem_req_ready;
    assign push         = mem_req_valid & mem_req_ready;

    // A kill in the pop cycle must already suppress the head fetch response.
    assign pop         = reset & mem_resp_valid & (count != '0);
    assign head_src    = src_q[rd_ptr];
    assign head_killed = killed_q[rd_ptr] | if_kill;

    assign d_resp_valid  = pop & ~head_src;
    assign if_resp_valid = pop & head_src & ~head_killed;
    assign d_resp_data   = mem_resp_data;
    assign if_resp_data  = mem_resp_data;

    assign err_unexpected_resp = err_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            src_q    <= '0;
            killed_q <= '0;
        end else begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                if (push && (wr_ptr == PW'(i))) begin
                    src_q[i]    <= f_sel;
                    killed_q[i] <= 1'b0;
                end else if (if_kill && src_q[i]) begin
                    killed_q[i] <= 1'b1;
                end
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (if_req_ready || !if_req_valid) begin
            starve_cnt <= '0;
        end else if (!fetch_prio) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (mem_resp_valid && (count == '0)) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_resp_valid;
    logic [31:0] if_resp_data;
    logic        if_kill;
    logic        d_req_valid;
    logic        d_req_ready;
    logic        d_req_we;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_data;
    logic [1:0]  d_req_size;
    logic        d_resp_valid;
    logic [31:0] d_resp_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic [1:0]  mem_req_size;
    logic        mem_req_src;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        err_unexpected_resp;

    int tests = 0;
    int fails = 0;

    logic [32:0] exp_req_q[$];
    logic [31:0] exp_d_q[$];
    logic [31:0] exp_if_q[$];

    mem_port_arbiter dut (
        .clock               (clock),
        .reset               (reset),
        .if_req_valid        (if_req_valid),
        .if_req_ready        (if_req_ready),
        .if_req_addr         (if_req_addr),
        .if_resp_valid       (if_resp_valid),
        .if_resp_data        (if_resp_data),
        .if_kill             (if_kill),
        .d_req_valid         (d_req_valid),
        .d_req_ready         (d_req_ready),
        .d_req_we            (d_req_we),
        .d_req_addr          (d_req_addr),
        .d_req_data          (d_req_data),
        .d_req_size          (d_req_size),
        .d_resp_valid        (d_resp_valid),
        .d_resp_data         (d_resp_data),
        .mem_req_valid       (mem_req_valid),
        .mem_req_ready       (mem_req_ready),
        .mem_req_we          (mem_req_we),
        .mem_req_addr        (mem_req_addr),
        .mem_req_data        (mem_req_data),
        .mem_req_size        (mem_req_size),
        .mem_req_src         (mem_req_src),
        .mem_resp_valid      (mem_resp_valid),
        .mem_resp_data       (mem_resp_data),
        .err_unexpected_resp (err_unexpected_resp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic exp_req(input logic src, input logic [31:0] addr);
        exp_req_q.push_back({src, addr});
    endtask

    task automatic check_empty(input string name);
        check({name, "_req_q_empty"}, exp_req_q.size(), 0);
        check({name, "_d_q_empty"},   exp_d_q.size(),   0);
        check({name, "_if_q_empty"},  exp_if_q.size(),  0);
    endtask

    // Monitor: every accepted request and every response is matched against the queues.
    always @(negedge clock) begin
        logic [32:0] er;
        logic [31:0] ed;
        if (mem_req_valid && mem_req_ready) begin
            tests++;
            if (exp_req_q.size() == 0) begin
                fails++;
                $display("FAIL mon_req: got src=%0d addr=%h expected no grant", mem_req_src, mem_req_addr);
            end else begin
                er = exp_req_q.pop_front();
                if ({mem_req_src, mem_req_addr} !== er) begin
                    fails++;
                    $display("FAIL mon_req: got src=%0d addr=%h expected src=%0d addr=%h",
                             mem_req_src, mem_req_addr, er[32], er[31:0]);
                end
            end
        end
        if (d_resp_valid) begin
            tests++;
            if (exp_d_q.size() == 0) begin
                fails++;
                $display("FAIL mon_d_resp: got %h expected no response", d_resp_data);
            end else begin
                ed = exp_d_q.pop_front();
                if (d_resp_data !== ed) begin
                    fails++;
                    $display("FAIL mon_d_resp: got %h expected %h", d_resp_data, ed);
                end
            end
        end
        if (if_resp_valid) begin
            tests++;
            if (exp_if_q.size() == 0) begin
                fails++;
                $display("FAIL mon_if_resp: got %h expected no response", if_resp_data);
            end else begin
                ed = exp_if_q.pop_front();
                if (if_resp_data !== ed) begin
                    fails++;
                    $display("FAIL mon_if_resp: got %h expected %h", if_resp_data, ed);
                end
            end
        end
    end

    initial begin
        reset          = 1'b0;
        if_req_valid   = 1'b0;
        if_req_addr    = 32'd0;
        if_kill        = 1'b0;
        d_req_valid    = 1'b0;
        d_req_we       = 1'b0;
        d_req_addr     = 32'd0;
        d_req_data     = 32'd0;
        d_req_size     = 2'd2;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'd0;

        repeat (2) @(posedge clock);
        #1;
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_err", err_unexpected_resp, 0);
        check("rst_count", dut.count, 0);
        reset = 1'b1;
        cyc();

        // Interleaved traffic
        exp_req(1'b0, 32'h100); exp_req(1'b1, 32'h0);
        exp_d_q.push_back(32'hAAAA); exp_if_q.push_back(32'hBBBB);
        mem_req_ready = 1'b1;
        d_req_valid = 1'b1; d_req_addr = 32'h100; d_req_we = 1'b0; d_req_size = 2'd2;
        if_req_valid = 1'b1; if_req_addr = 32'h0;
        #1;
        check("t1_src_data", mem_req_src, 0);
        check("t1_d_ready", d_req_ready, 1);
        check("t1_if_ready_low", if_req_ready, 0);
        cyc();
        d_req_valid = 1'b0;
        #1;
        check("t1_src_fetch", mem_req_src, 1);
        check("t1_if_ready", if_req_ready, 1);
        check("t1_fetch_size", mem_req_size, 2);
        cyc();
        if_req_valid = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hAAAA;
        #1;
        check("t1_d_resp", d_resp_valid, 1);
        cyc();
        mem_resp_data = 32'hBBBB;
        #1;
        check("t1_if_resp", if_resp_valid, 1);
        cyc();
        mem_resp_valid = 1'b0;
        check_empty("t1");

        // Starvation: fetch wins on the ninth cycle
        d_req_valid = 1'b1; d_req_addr = 32'h200; if_req_valid = 1'b1; if_req_addr = 32'h40;
        for (int i = 0; i < 10; i++) begin
            if (i == 8) begin
                exp_req(1'b1, 32'h40); exp_if_q.push_back(32'h1000 + i);
            end else begin
                exp_req(1'b0, 32'h200); exp_d_q.push_back(32'h1000 + i);
            end
            mem_resp_valid = (i > 0);
            mem_resp_data  = 32'h1000 + i - 1;
            #1;
            if (i < 8) check("t2_data_grant", d_req_ready, 1);
            if (i == 8) begin
                check("t2_starve_sat", dut.starve_cnt, 8);
                check("t2_fetch_grant", if_req_ready, 1);
            end
            if (i == 9) check("t2_starve_clr", dut.starve_cnt, 0);
            cyc();
        end
        d_req_valid = 1'b0; if_req_valid = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h1009;
        cyc();
        mem_resp_valid = 1'b0;
        check_empty("t2");

        // Full FIFO
        d_req_valid = 1'b1; d_req_addr = 32'h300;
        for (int i = 0; i < 4; i++) begin
            exp_req(1'b0, 32'h300); exp_d_q.push_back(32'h3000 + i);
            cyc();
        end
        if_req_valid = 1'b1; if_req_addr = 32'h80;
        #1;
        check("t3_count_full", dut.count, 4);
        check("t3_full_d_ready", d_req_ready, 0);
        check("t3_full_if_ready", if_req_ready, 0);
        check("t3_full_req_valid", mem_req_valid, 0);
        cyc();
        mem_resp_valid = 1'b1; mem_resp_data = 32'h3000;
        #1;
        check("t3_pop_d_ready", d_req_ready, 0);
        check("t3_pop_if_ready", if_req_ready, 0);
        cyc();
        mem_resp_valid = 1'b0;
        exp_req(1'b0, 32'h300); exp_d_q.push_back(32'h3004);
        #1;
        check("t3_resume", d_req_ready, 1);
        cyc();
        d_req_valid = 1'b0; if_req_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            mem_resp_valid = 1'b1; mem_resp_data = 32'h3000 + i;
            cyc();
        end
        mem_resp_valid = 1'b0;
        check_empty("t3");

        // Kill with three fetches and a write outstanding
        if_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_req_addr = 32'h10 + 4 * i;
            exp_req(1'b1, 32'h10 + 4 * i);
            cyc();
        end
        if_req_valid = 1'b0;
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h400; d_req_data = 32'hDEADBEEF; d_req_size = 2'd1;
        exp_req(1'b0, 32'h400); exp_d_q.push_back(32'h5003);
        #1;
        check("t4_we", mem_req_we, 1);
        check("t4_wdata", mem_req_data, 32'hDEADBEEF);
        check("t4_size", mem_req_size, 1);
        cyc();
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_size = 2'd2;
        if_kill = 1'b1; if_req_valid = 1'b1;
        #1;
        check("t4_kill_no_grant", if_req_ready, 0);
        cyc();
        if_kill = 1'b0; if_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1; mem_resp_data = 32'h5000 + i;
            #1;
            if (i < 3) check("t4_if_dropped", if_resp_valid, 0);
            else       check("t4_d_resp", d_resp_valid, 1);
            cyc();
        end
        mem_resp_valid = 1'b0;
        check_empty("t4");

        // Kill on the head pop, FIFO not full
        if_req_valid = 1'b1; if_req_addr = 32'h20;
        exp_req(1'b1, 32'h20);
        cyc();
        if_req_valid = 1'b0; d_req_valid = 1'b1; d_req_addr = 32'h500;
        exp_req(1'b0, 32'h500); exp_d_q.push_back(32'h6001);
        cyc();
        d_req_valid = 1'b0; if_kill = 1'b1; if_req_valid = 1'b1; if_req_addr = 32'h24;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h6000;
        #1;
        check("t5_head_dropped", if_resp_valid, 0);
        check("t5_kill_no_grant", if_req_ready, 0);
        check("t5_kill_req_valid", mem_req_valid, 0);
        cyc();
        if_kill = 1'b0; mem_resp_data = 32'h6001;
        exp_req(1'b1, 32'h24); exp_if_q.push_back(32'h6002);
        #1;
        check("t5_d_resp", d_resp_valid, 1);
        check("t5_fetch_after_kill", if_req_ready, 1);
        cyc();
        if_req_valid = 1'b0; mem_resp_data = 32'h6002;
        #1;
        check("t5_new_fetch_resp", if_resp_valid, 1);
        cyc();
        mem_resp_valid = 1'b0;
        check_empty("t5");

        // Reset with two requests outstanding, then an orphan response
        d_req_valid = 1'b1; d_req_addr = 32'h600;
        exp_req(1'b0, 32'h600);
        cyc();
        d_req_addr = 32'h604;
        exp_req(1'b0, 32'h604);
        cyc();
        d_req_addr = 32'h608; if_req_valid = 1'b1; if_req_addr = 32'h70;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h7777;
        reset = 1'b0;
        #1;
        check("t6_rst_req_valid", mem_req_valid, 0);
        check("t6_rst_d_ready", d_req_ready, 0);
        check("t6_rst_if_ready", if_req_ready, 0);
        check("t6_rst_d_resp", d_resp_valid, 0);
        check("t6_rst_if_resp", if_resp_valid, 0);
        check("t6_rst_addr", mem_req_addr, 0);
        check("t6_rst_src", mem_req_src, 0);
        check("t6_rst_err", err_unexpected_resp, 0);
        cyc();
        check("t6_rst_err_held", err_unexpected_resp, 0);
        d_req_valid = 1'b0; if_req_valid = 1'b0; mem_resp_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("t6_count_zero", dut.count, 0);
        cyc();
        mem_resp_valid = 1'b1; mem_resp_data = 32'h7000;
        #1;
        check("t6_orphan_d_resp", d_resp_valid, 0);
        check("t6_orphan_if_resp", if_resp_valid, 0);
        cyc();
        mem_resp_valid = 1'b0;
        #1;
        check("t6_err_set", err_unexpected_resp, 1);
        repeat (3) cyc();
        check("t6_err_sticky", err_unexpected_resp, 1);
        check_empty("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
